// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and a per-register
// pending scoreboard used by the issue/hazard logic.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int DBG_REG = NREGS - 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rvalid,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_sel,
    input  logic                  flush,
    output logic [AW:0]           pend_cnt,
    output logic [DATA_W-1:0]     dbg_dat
);

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [NREGS-1:0]  pend_reg;
    logic [NREGS-1:0]  pend_next;
    logic [AW:0]       cnt_reg;
    logic [AW:0]       cnt_next;
    logic [DATA_W-1:0] dbg_reg;

    // Per-register write decode; the highest-numbered matching port wins.
    logic [NREGS-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_val [NREGS];

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
        end
        for (int r = 1; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (wsel[j*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wdat[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Register storage; entry 0 has no write decode so it stays at its reset 0.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    regs_reg[gi] <= '0;
                end else if (wr_hit[gi]) begin
                    regs_reg[gi] <= wr_val[gi];
                end
            end
        end
    endgenerate

    // Scoreboard: flush beats issue, and an issue supersedes a same-cycle write.
    always_comb begin
        pend_next = pend_reg;
        if (flush) begin
            pend_next = '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    pend_next[r] = 1'b0;
                end
            end
            if (iss_en && (iss_sel != '0)) begin
                pend_next[iss_sel] = 1'b1;
            end
        end
        pend_next[0] = 1'b0;
    end

    logic [AW:0] set_cnt;
    logic [AW:0] clr_cnt;

    always_comb begin
        set_cnt = '0;
        clr_cnt = '0;
        for (int r = 1; r < NREGS; r++) begin
            set_cnt = set_cnt + (AW+1)'(pend_next[r] & ~pend_reg[r]);
            clr_cnt = clr_cnt + (AW+1)'(pend_reg[r] & ~pend_next[r]);
        end
        if (flush) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + set_cnt - clr_cnt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend_reg <= '0;
            cnt_reg  <= '0;
            dbg_reg  <= '0;
        end else begin
            pend_reg <= pend_next;
            cnt_reg  <= cnt_next;
            dbg_reg  <= wr_hit[DBG_REG] ? wr_val[DBG_REG] : regs_reg[DBG_REG];
        end
    end

    assign pend_cnt = cnt_reg;
    assign dbg_dat  = dbg_reg;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]     sel;
            logic              hit;
            logic [DATA_W-1:0] val;
            logic [DATA_W-1:0] dat;
            logic              vld;

            assign sel = rsel[gi*AW +: AW];

            always_comb begin
                hit = 1'b0;
                val = regs_reg[sel];
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && (wsel[j*AW +: AW] == sel)) begin
                        hit = 1'b1;
                        val = wdat[j*DATA_W +: DATA_W];
                    end
                end
                if (sel == '0) begin
                    dat = '0;
                    vld = 1'b1;
                end else begin
                    dat = val;
                    vld = hit | ~pend_reg[sel];
                end
            end

            assign rdat[gi*DATA_W +: DATA_W] = dat;
            assign rvalid[gi]                = vld;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, randomized traffic against a
// behavioural model, and an asynchronous mid-stream reset.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          CLK;
    logic          nRST;
    logic [2*AW-1:0] rsel;
    logic [2*DW-1:0] rdat;
    logic [1:0]      rvalid;
    logic [1:0]      wen;
    logic [2*AW-1:0] wsel;
    logic [2*DW-1:0] wdat;
    logic            iss_en;
    logic [AW-1:0]   iss_sel;
    logic            flush;
    logic [AW:0]     pend_cnt;
    logic [DW-1:0]   dbg_dat;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2), .DBG_REG(NR-1)) dut (
        .CLK(CLK), .nRST(nRST), .rsel(rsel), .rdat(rdat), .rvalid(rvalid),
        .wen(wen), .wsel(wsel), .wdat(wdat), .iss_en(iss_en), .iss_sel(iss_sel),
        .flush(flush), .pend_cnt(pend_cnt), .dbg_dat(dbg_dat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: register contents and set of pending registers.
    logic [DW-1:0] mdl_regs [NR];
    bit            mdl_pend [NR];

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            mdl_regs[r] = '0;
            mdl_pend[r] = 1'b0;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < NR; r++) n += int'(mdl_pend[r]);
        return n;
    endfunction

    task automatic model_read(input logic [AW-1:0] s, output logic [DW-1:0] d, output logic v);
        logic hit = 1'b0;
        d = mdl_regs[s];
        for (int j = 0; j < 2; j++) begin
            if (wen[j] && wsel[j*AW +: AW] == s) begin
                hit = 1'b1;
                d   = wdat[j*DW +: DW];
            end
        end
        if (s == 0) begin
            d = '0;
            v = 1'b1;
        end else begin
            v = hit || !mdl_pend[s];
        end
    endtask

    task automatic model_step();
        for (int j = 0; j < 2; j++) begin
            if (wen[j] && wsel[j*AW +: AW] != 0) begin
                mdl_regs[wsel[j*AW +: AW]] = wdat[j*DW +: DW];
                mdl_pend[wsel[j*AW +: AW]] = 1'b0;
            end
        end
        if (flush) begin
            for (int r = 0; r < NR; r++) mdl_pend[r] = 1'b0;
        end else if (iss_en && iss_sel != 0) begin
            mdl_pend[iss_sel] = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle with the inputs already applied: check reads mid-cycle,
    // advance the model at the edge, check the registered outputs just after.
    task automatic do_cycle();
        logic [DW-1:0] ed;
        logic          ev;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            model_read(rsel[i*AW +: AW], ed, ev);
            check($sformatf("rdat%0d", i), 64'(rdat[i*DW +: DW]), 64'(ed));
            check($sformatf("rvalid%0d", i), 64'(rvalid[i]), 64'(ev));
        end
        @(posedge CLK);
        model_step();
        #1;
        check("pend_cnt", 64'(pend_cnt), 64'(model_count()));
        check("dbg_dat", 64'(dbg_dat), 64'(mdl_regs[NR-1]));
        $display("cyc %0d wen=%b ws=%0d/%0d iss=%b/%0d fl=%b rs=%0d/%0d rd=%h/%h rv=%b cnt=%0d",
                 cyc, wen, wsel[AW +: AW], wsel[0 +: AW], iss_en, iss_sel, flush,
                 rsel[AW +: AW], rsel[0 +: AW], rdat[DW +: DW], rdat[0 +: DW], rvalid, pend_cnt);
        cyc++;
    endtask

    task automatic idle_inputs();
        wen = '0; wsel = '0; wdat = '0; iss_en = 1'b0; iss_sel = '0; flush = 1'b0; rsel = '0;
    endtask

    typedef struct {
        logic [1:0]    wen;
        logic [AW-1:0] ws0, ws1;
        logic [DW-1:0] wd0, wd1;
        logic [AW-1:0] rs0, rs1;
        logic          iss;
        logic [AW-1:0] isel;
        logic          fl;
        logic [DW-1:0] er0, er1;
        logic [1:0]    erv;
        logic [AW:0]   ecnt;
        logic [DW-1:0] edbg;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [AW-1:0] rnd_sel();
        if ($urandom_range(0, 3) == 0) return AW'(NR - 1);
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        //           wen    ws0 ws1 wd0           wd1           rs0 rs1 iss isel fl er0           er1           erv    cnt edbg
        vecs[0]  = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  31, 0,  0,   0, 32'h0,        32'h0,        2'b11, 0,  32'h0};
        vecs[1]  = '{2'b01, 5,  0,  32'hDEADBEEF, 32'h0,        0,  5,  0,  0,   0, 32'h0,        32'hDEADBEEF, 2'b11, 0,  32'h0};
        vecs[2]  = '{2'b01, 0,  0,  32'h1234,     32'h0,        5,  0,  0,  0,   0, 32'hDEADBEEF, 32'h0,        2'b11, 0,  32'h0};
        vecs[3]  = '{2'b11, 7,  7,  32'h11111111, 32'h22222222, 7,  0,  0,  0,   0, 32'h22222222, 32'h0,        2'b11, 0,  32'h0};
        vecs[4]  = '{2'b00, 0,  0,  32'h0,        32'h0,        7,  3,  1,  3,   0, 32'h22222222, 32'h0,        2'b11, 1,  32'h0};
        vecs[5]  = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  3,  0,  0,   0, 32'h0,        32'h0,        2'b01, 1,  32'h0};
        vecs[6]  = '{2'b00, 0,  0,  32'h0,        32'h0,        0,  3,  0,  0,   0, 32'h0,        32'h0,        2'b01, 1,  32'h0};
        vecs[7]  = '{2'b01, 3,  0,  32'hA5,       32'h0,        3,  3,  0,  0,   0, 32'hA5,       32'hA5,       2'b11, 0,  32'h0};
        vecs[8]  = '{2'b10, 0,  4,  32'h0,        32'h99,       4,  0,  1,  4,   0, 32'h99,       32'h0,        2'b11, 1,  32'h0};
        vecs[9]  = '{2'b00, 0,  0,  32'h0,        32'h0,        4,  0,  1,  1,   0, 32'h99,       32'h0,        2'b10, 2,  32'h0};
        vecs[10] = '{2'b00, 0,  0,  32'h0,        32'h0,        1,  4,  1,  2,   0, 32'h0,        32'h99,       2'b00, 3,  32'h0};
        vecs[11] = '{2'b00, 0,  0,  32'h0,        32'h0,        2,  0,  1,  6,   0, 32'h0,        32'h0,        2'b10, 4,  32'h0};
        vecs[12] = '{2'b00, 0,  0,  32'h0,        32'h0,        6,  9,  1,  9,   1, 32'h0,        32'h0,        2'b10, 0,  32'h0};
        vecs[13] = '{2'b00, 0,  0,  32'h0,        32'h0,        9,  4,  0,  0,   0, 32'h0,        32'h99,       2'b11, 0,  32'h0};
        vecs[14] = '{2'b01, 31, 0,  32'hCAFEF00D, 32'h0,        31, 0,  0,  0,   0, 32'hCAFEF00D, 32'h0,        2'b11, 0,  32'hCAFEF00D};
        vecs[15] = '{2'b00, 0,  0,  32'h0,        32'h0,        31, 7,  0,  0,   0, 32'hCAFEF00D, 32'h22222222, 2'b11, 0,  32'hCAFEF00D};
        vecs[16] = '{2'b00, 0,  0,  32'h0,        32'h0,        10, 0,  1,  10,  0, 32'h0,        32'h0,        2'b11, 1,  32'hCAFEF00D};
        vecs[17] = '{2'b01, 10, 0,  32'h77,       32'h0,        10, 10, 0,  0,   1, 32'h77,       32'h77,       2'b11, 0,  32'hCAFEF00D};
        vecs[18] = '{2'b00, 0,  0,  32'h0,        32'h0,        10, 0,  0,  0,   0, 32'h77,       32'h0,        2'b11, 0,  32'hCAFEF00D};

        nRST = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        // Reset state: every register reads 0 and valid on both ports.
        for (int r = 0; r < NR; r++) begin
            rsel = {AW'(r), AW'(r)};
            #1;
            check("rst_rdat0", 64'(rdat[0 +: DW]), 64'h0);
            check("rst_rdat1", 64'(rdat[DW +: DW]), 64'h0);
            check("rst_rvalid", 64'(rvalid), 64'h3);
        end
        check("rst_pend_cnt", 64'(pend_cnt), 64'h0);
        check("rst_dbg", 64'(dbg_dat), 64'h0);
        $display("reset state checked for %0d registers", NR);

        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Directed vectors: table expectations plus model tracking.
        for (int v = 0; v < 19; v++) begin
            wen = vecs[v].wen;
            wsel = {vecs[v].ws1, vecs[v].ws0};
            wdat = {vecs[v].wd1, vecs[v].wd0};
            rsel = {vecs[v].rs1, vecs[v].rs0};
            iss_en = vecs[v].iss; iss_sel = vecs[v].isel; flush = vecs[v].fl;
            @(negedge CLK);
            check($sformatf("vec%0d_rdat0", v), 64'(rdat[0 +: DW]), 64'(vecs[v].er0));
            check($sformatf("vec%0d_rdat1", v), 64'(rdat[DW +: DW]), 64'(vecs[v].er1));
            check($sformatf("vec%0d_rvalid", v), 64'(rvalid), 64'(vecs[v].erv));
            @(posedge CLK);
            model_step();
            #1;
            check($sformatf("vec%0d_cnt", v), 64'(pend_cnt), 64'(vecs[v].ecnt));
            check($sformatf("vec%0d_dbg", v), 64'(dbg_dat), 64'(vecs[v].edbg));
            $display("vec %0d rd=%h/%h rv=%b cnt=%0d dbg=%h", v, rdat[DW +: DW], rdat[0 +: DW],
                     rvalid, pend_cnt, dbg_dat);
        end

        // Randomized traffic concentrated on a few registers to force collisions.
        for (int n = 0; n < 400; n++) begin
            wen     = 2'($urandom_range(0, 3));
            wsel    = {rnd_sel(), rnd_sel()};
            wdat    = {32'($urandom), 32'($urandom)};
            rsel    = {rnd_sel(), rnd_sel()};
            iss_en  = ($urandom_range(0, 9) < 3);
            iss_sel = rnd_sel();
            flush   = ($urandom_range(0, 19) == 0);
            do_cycle();
        end

        // Asynchronous reset mid-stream with pending state and r31 populated.
        wen = 2'b01; wsel = {AW'(0), AW'(31)}; wdat = {32'h0, 32'h5555AAAA};
        rsel = {AW'(12), AW'(31)}; iss_en = 1'b1; iss_sel = AW'(12); flush = 1'b0;
        do_cycle();
        idle_inputs();
        rsel = {AW'(12), AW'(31)};
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check("mid_rst_cnt", 64'(pend_cnt), 64'h0);
        check("mid_rst_dbg", 64'(dbg_dat), 64'h0);
        check("mid_rst_rdat", 64'(rdat), 64'h0);
        check("mid_rst_rvalid", 64'(rvalid), 64'h3);
        $display("mid-stream reset cnt=%0d dbg=%h rv=%b", pend_cnt, dbg_dat, rvalid);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        wen = 2'b10; wsel = {AW'(31), AW'(0)}; wdat = {32'h0000ABCD, 32'h0};
        rsel = {AW'(12), AW'(31)};
        do_cycle();
        check("post_rst_dbg", 64'(dbg_dat), 64'h0000ABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the pipelined CPU datapath. It generalises the single-write, two-read register file to configurable width, depth, read-port count and write-port count. It adds same-cycle write-to-read bypass and a per-register pending scoreboard, so hazard logic can detect reads of registers whose producer has not yet written back. It sits between decode (read/issue) and writeback.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers; power of two, ≥ 2; AW = clog2(NREGS)
- NRD, 2, number of read ports (1–4)
- NWR, 2, number of write ports (1–2)
- DBG_REG, NREGS-1, index mirrored on dbg_dat

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- rsel  in  NRD×AW  read select per port
- rdat  out  NRD×DATA_W  read data per port
- rvalid  out  NRD  read data is final (register not pending, or resolved by bypass)
- wen  in  NWR  write enable per write port
- wsel  in  NWR×AW  write select per write port
- wdat  in  NWR×DATA_W  write data per write port
- iss_en  in  1  mark destination iss_sel pending
- iss_sel  in  AW  destination being issued
- flush  in  1  clear all pending bits
- pend_cnt  out  AW+1  number of registers currently pending
- dbg_dat  out  DATA_W  registered value of register DBG_REG

## Operation
- Register 0 always reads 0 and is never written. Register 0 is never pending, and its rvalid is always 1.
- Writes: at the rising edge, register[wsel[j]] ← wdat[j] for each j with wen[j]=1 and wsel[j]≠0.
  - If two ports target the same register, port NWR-1 wins.
- Reads are combinational. For each port i:
  - If rsel[i]=0: rdat=0.
  - Else if any enabled write matches rsel[i] this cycle: rdat = that wdat, using the highest matching port index.
  - Else: rdat = the stored register value.
- Pending bits pend[NREGS-1:1] update at the rising edge in this priority order:
  1. flush=1: all bits ← 0; iss_en is ignored.
  2. iss_en=1 and iss_sel≠0: pend[iss_sel] ← 1. This wins over a same-cycle write to the same register (a new producer supersedes the old one).
  3. Otherwise, for any enabled write to register r≠0: pend[r] ← 0.
- rvalid[i] = (rsel[i]=0) | !pend[rsel[i]] | (an enabled write matches rsel[i] this cycle).
- Writes to non-pending registers are legal; the pending state is unchanged.
- pend_cnt is a registered count equal to popcount(pend) after each edge. It is maintained incrementally:
  - +1 per newly set bit, −1 per newly cleared bit.
  - Forced to 0 on flush.
  - Setting an already-set bit or clearing a clear bit changes nothing.
  - It must always equal the popcount; the bench checks this every cycle.
- dbg_dat holds register[DBG_REG] as stored after the edge (no bypass).

## Timing
- Reset (nRST low, asynchronous): all registers 0, all pend bits 0, pend_cnt 0, dbg_dat 0. Consequently rdat=0 and rvalid=1 for every rsel while no writes are presented.
- Reset asserted mid-operation discards all writes and issues in flight; the first edge after nRST rises is a normal cycle.
- Read latency: 0 cycles; a write on edge N is visible via bypass in cycle N−1 and via storage from cycle N.
- Pending latency: an issue at edge N makes rvalid=0 for that register from cycle N until the cycle its write is presented (bypass) and the bit clears at that edge.
- Issue and write to the same register in the same cycle: the data is stored and the bit ends set.
- Flush plus a write in the same cycle: the write is performed and all bits end clear.
- No handshake backpressure: the block always accepts writes and issues.

## Test plan
- Reset, then read r0–r31 on all ports -> rdat=0, rvalid=1, pend_cnt=0, dbg_dat=0.
- Write r5=0xDEADBEEF on port 0 while rsel[1]=5 -> rdat[1]=0xDEADBEEF in the same cycle; next cycle rdat[0] with rsel=5 returns 0xDEADBEEF. Write r0=0x1234 -> r0 still reads 0.
- Both ports write r7 (0x11111111 port 0, 0x22222222 port 1) -> bypass and stored value are both 0x22222222.
- Issue r3, then read r3 for 2 cycles -> rvalid=0 and pend_cnt=1. Then write r3=0xA5 -> rvalid=1 with rdat=0xA5 in the write cycle; pend_cnt=0 after the edge.
- Issue r4 and write r4=0x99 in the same cycle -> r4 stores 0x99 and pend[4] stays 1. Issue r1, r2, r6, then flush together with iss_en for r9 -> pend_cnt=0 and r9 is not pending.
- DBG_REG=31: write r31=0xCAFEF00D -> dbg_dat=0xCAFEF00D one edge later. Pulse nRST low mid-stream -> every output returns to 0 / rvalid=1 immediately.
